sm_result_display: RTL and testbench
====================================

# sm_result_display

Result display driver for the 4-bit sign-magnitude adder/subtractor. It latches one result word plus its flags (carry, zero, overflow) on a load strobe. It then scans them continuously onto a 4-digit, common-anode, multiplexed 7-segment display. The block is the consumer end of the adder's result interface and sits between the arithmetic datapath and the board's display pins.

## Interface
Parameters:
- SCAN_DIV, default 50000: clock cycles per digit slot; minimum 2.
- BLINK_DIV, default 16: full scan frames (4 slots each) per blink-phase toggle; minimum 1.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- load  in  1  capture strobe for result/flags; sampled every edge.
- result  in  4  sign-magnitude value: [3] is the sign (1 = negative), [2:0] is the magnitude, 0..7.
- carry  in  1  carry flag.
- zero  in  1  zero flag.
- overflow  in  1  overflow flag.
- an  out  4  digit enables, active-low; an[0] is the rightmost digit.
- seg  out  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
- dp  out  1  decimal point, active-low; held 1 (off) always.
- ack  out  1  one-cycle pulse confirming a capture.

## Operation
- Capture: when load=1 at an edge, the values of result, carry, zero and overflow at that edge go into the holding registers. Back-to-back loads capture every cycle; the last one wins.
- Scan counter div_cnt counts 0..SCAN_DIV-1. On the terminal count it wraps to 0 and digit index idx advances (3 wraps to 0).
- Frame counter counts idx wraps. When it reaches BLINK_DIV-1 on a wrap, it returns to 0 and blink_on toggles.
- While latched overflow=0, blink_on is forced to 1 and the frame counter is held at 0.
- Digit content, per idx:
  - Digit 0: magnitude glyph for 0..7. Blanked when latched overflow=1 and blink_on=0.
  - Digit 1: '-' if the sign bit is 1 and latched zero=0, otherwise blank. A latched zero therefore suppresses a negative sign, so "-0" is never shown. Blanked under the same blink condition as digit 0.
  - Digit 2: 'C' if latched carry=1, otherwise blank.
  - Digit 3: lowercase 'o' if latched overflow=1, otherwise blank. This digit never blinks.
- Glyphs, as active-low {g..a} values:
  - Digits: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78.
  - Symbols: '-'=0x3F, 'C'=0x46, 'o'=0x23, blank=0x7F.
- an is one-hot-low, with bit idx = 0.

## Timing
- Reset values:
  - Outputs: an=4'b1111, seg=7'h7F, dp=1, ack=0.
  - Internal state: holding registers all 0, div_cnt=0, idx=0, frame counter=0, blink_on=1.
- an, seg and ack are registered. They reflect the state present before the edge that updates them, so every output has exactly one cycle of latency.
- First edge after reset release: an=4'b1110, seg=0x40 (magnitude 0 on digit 0).
- Load at edge E: holding registers update at E. ack=1 during the cycle after E+1. seg shows the new data at E+1 for whichever digit is active. A load does not disturb div_cnt, idx, the frame counter or blink_on.
- Digit advance: at the edge where div_cnt=SCAN_DIV-1, idx increments. an shows the new digit one edge later. Each digit is therefore active for exactly SCAN_DIV cycles.
- Blink period: one phase lasts SCAN_DIV*4*BLINK_DIV cycles.
- Overflow latched 1→0: on the capture edge, blink_on is set to 1 and the frame counter is cleared.
- Simultaneous load and slot advance at the same edge: both take effect.
- Reset mid-scan: rst_n=0 at any edge returns every register to its reset value at that edge. Reset dominates load.

## Structure
- Shared package contents:
  - glyph constants: GLYPH_DIG[0:7], GLYPH_MINUS, GLYPH_C, GLYPH_O, GLYPH_BLANK;
  - digit index width (2);
  - digit position constants (DIG_MAG=0, DIG_SIGN=1, DIG_CARRY=2, DIG_OVF=3).
- Sub-module seg7_glyph: combinational decoder mapping a small symbol code (0..7, minus, C, o, blank) to the 7-bit active-low pattern.
- The top level holds the capture registers, the scan/frame/blink counters and the output registers.

## Test plan
All scenarios use SCAN_DIV=4 and BLINK_DIV=2.
- Reset: hold rst_n=0 for 3 edges → an=1111, seg=0x7F, dp=1, ack=0. First edge after release → an=1110, seg=0x40.
- Negative result: load result=4'b1101, zero=0, carry=0, overflow=0 → ack pulse, then:
  - slot 0: seg=0x12;
  - slot 1: seg=0x3F;
  - slots 2 and 3: seg=0x7F;
  - each slot lasts 4 cycles.
- Suppressed negative zero: load result=4'b1000, zero=1 → slot 1 seg=0x7F, slot 0 seg=0x40.
- Overflow and carry: load result=4'b0011, carry=1, overflow=1 →
  - slot 2 seg=0x46, slot 3 seg=0x23;
  - slots 0 and 1 alternate between 0x30/0x7F and blank every 32 cycles.
  - Then load overflow=0 → slots 0 and 1 stop blinking immediately.
- Mid-slot load: load at div_cnt=1 → seg changes on the next edge; an and the slot boundary are unshifted.
- Mid-scan reset: assert rst_n=0 at idx=2, div_cnt=2 → reset values on that edge; the scan restarts at idx=0 after release.

Source files
------------

// File: rtl/sm_result_display_pkg.sv
// Shared constants for the sign-magnitude result display: glyph patterns,
// symbol codes and digit positions.
package sm_result_display_pkg;

    localparam int IDX_W = 2;

    localparam logic [IDX_W-1:0] DIG_MAG   = 2'd0;
    localparam logic [IDX_W-1:0] DIG_SIGN  = 2'd1;
    localparam logic [IDX_W-1:0] DIG_CARRY = 2'd2;
    localparam logic [IDX_W-1:0] DIG_OVF   = 2'd3;

    typedef enum logic [3:0] {
        SYM_0     = 4'd0,
        SYM_1     = 4'd1,
        SYM_2     = 4'd2,
        SYM_3     = 4'd3,
        SYM_4     = 4'd4,
        SYM_5     = 4'd5,
        SYM_6     = 4'd6,
        SYM_7     = 4'd7,
        SYM_MINUS = 4'd8,
        SYM_C     = 4'd9,
        SYM_O     = 4'd10,
        SYM_BLANK = 4'd11
    } symbol_e;

    // Active-low segment patterns, ordered {g,f,e,d,c,b,a}.
    localparam logic [6:0] GLYPH_DIG [0:7] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78
    };
    localparam logic [6:0] GLYPH_MINUS = 7'h3F;
    localparam logic [6:0] GLYPH_C     = 7'h46;
    localparam logic [6:0] GLYPH_O     = 7'h23;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

endpackage

// File: rtl/sm_result_display_seg7_glyph.sv
// Combinational decoder from a display symbol code to its active-low
// 7-segment pattern.
module seg7_glyph
    import sm_result_display_pkg::*;
(
    input  symbol_e    sym,
    output logic [6:0] glyph
);

    logic [3:0] code;

    assign code = sym;

    always_comb begin
        glyph = GLYPH_BLANK;
        case (sym)
            SYM_MINUS: glyph = GLYPH_MINUS;
            SYM_C:     glyph = GLYPH_C;
            SYM_O:     glyph = GLYPH_O;
            SYM_BLANK: glyph = GLYPH_BLANK;
            default:   glyph = GLYPH_DIG[code[2:0]];
        endcase
    end

endmodule

// File: rtl/sm_result_display.sv
// Latches an adder result with its flags and scans them onto a 4-digit
// multiplexed common-anode display, blinking the value while overflow is set.
module sm_result_display
    import sm_result_display_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] result,
    input  logic       carry,
    input  logic       zero,
    input  logic       overflow,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       ack
);

    localparam int DIV_W   = $clog2(SCAN_DIV);
    localparam int FRAME_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [3:0]         res_q;
    logic               carry_q;
    logic               zero_q;
    logic               ovf_q;
    logic               load_seen;
    logic [DIV_W-1:0]   div_cnt;
    logic [IDX_W-1:0]   idx;
    logic [FRAME_W-1:0] frame_cnt;
    logic               blink_on;

    logic       slot_end;
    logic       frame_wrap;
    logic       ovf_next;
    logic       blink_off;
    symbol_e    sym;
    logic [6:0] glyph;

    assign slot_end   = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign frame_wrap = slot_end && (idx == IDX_W'(3));
    // Looking at the value being captured lets a 1->0 overflow load stop
    // the blink on the capture edge itself.
    assign ovf_next   = load ? overflow : ovf_q;
    assign blink_off  = ovf_q && !blink_on;
    assign dp         = 1'b1;

    always_comb begin
        sym = SYM_BLANK;
        case (idx)
            DIG_MAG: begin
                if (!blink_off) sym = symbol_e'({1'b0, res_q[2:0]});
            end
            DIG_SIGN: begin
                if (res_q[3] && !zero_q && !blink_off) sym = SYM_MINUS;
            end
            DIG_CARRY: begin
                if (carry_q) sym = SYM_C;
            end
            DIG_OVF: begin
                if (ovf_q) sym = SYM_O;
            end
            default: sym = SYM_BLANK;
        endcase
    end

    seg7_glyph u_glyph (
        .sym   (sym),
        .glyph (glyph)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q     <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            load_seen <= 1'b0;
            div_cnt   <= '0;
            idx       <= '0;
            frame_cnt <= '0;
            blink_on  <= 1'b1;
            an        <= 4'b1111;
            seg       <= GLYPH_BLANK;
            ack       <= 1'b0;
        end else begin
            if (load) begin
                res_q   <= result;
                carry_q <= carry;
                zero_q  <= zero;
                ovf_q   <= overflow;
            end
            load_seen <= load;
            ack       <= load_seen;

            div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
            if (slot_end) idx <= idx + 1'b1;

            if (!ovf_next) begin
                frame_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (frame_wrap) begin
                if (frame_cnt == FRAME_W'(BLINK_DIV - 1)) begin
                    frame_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            an  <= ~(4'b0001 << idx);
            seg <= glyph;
        end
    end

endmodule

// File: tb/tb_sm_result_display.sv
// Directed bench for sm_result_display with SCAN_DIV=4, BLINK_DIV=2.
// Edge numbers in comments count rising edges after reset release.
module tb_sm_result_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [3:0] result;
    logic       carry;
    logic       zero;
    logic       overflow;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ack;

    int checks   = 0;
    int failures = 0;
    int n        = 0;

    sm_result_display #(
        .SCAN_DIV  (4),
        .BLINK_DIV (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .result   (result),
        .carry    (carry),
        .zero     (zero),
        .overflow (overflow),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .ack      (ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic cyc(input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_ack);
        tick();
        check($sformatf("n%0d an", n), {4'h0, an}, {4'h0, e_an});
        check($sformatf("n%0d seg", n), {1'b0, seg}, {1'b0, e_seg});
        check($sformatf("n%0d ack", n), {7'h0, ack}, {7'h0, e_ack});
        check($sformatf("n%0d dp", n), {7'h0, dp}, 8'h01);
    endtask

    task automatic slot(input logic [3:0] e_an, input logic [6:0] e_seg, input int cnt);
        for (int i = 0; i < cnt; i++) cyc(e_an, e_seg, 1'b0);
    endtask

    // One full scan with overflow latched and result 0011, carry 1.
    task automatic frame_ovf(input logic [6:0] seg0);
        slot(4'b1110, seg0, 4);
        slot(4'b1101, 7'h7F, 4);
        slot(4'b1011, 7'h46, 4);
        slot(4'b0111, 7'h23, 4);
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; result = 4'h0;
        carry = 1'b0; zero = 1'b0; overflow = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst an", {4'h0, an}, 8'h0F);
        check("rst seg", {1'b0, seg}, 8'h7F);
        check("rst dp", {7'h0, dp}, 8'h01);
        check("rst ack", {7'h0, ack}, 8'h00);
        rst_n = 1'b1;

        cyc(4'b1110, 7'h40, 1'b0);                      // n1

        // Negative result 1101 loaded mid-slot (div_cnt=1)
        load = 1'b1; result = 4'b1101;
        cyc(4'b1110, 7'h40, 1'b0);                      // n2: capture edge
        load = 1'b0;
        cyc(4'b1110, 7'h12, 1'b1);                      // n3
        cyc(4'b1110, 7'h12, 1'b0);                      // n4
        slot(4'b1101, 7'h3F, 4);                        // n5-8
        slot(4'b1011, 7'h7F, 4);
        slot(4'b0111, 7'h7F, 4);
        slot(4'b1110, 7'h12, 4);                        // n17-20

        // Negative zero: sign suppressed
        load = 1'b1; result = 4'b1000; zero = 1'b1;
        cyc(4'b1101, 7'h3F, 1'b0);                      // n21: old data
        load = 1'b0;
        cyc(4'b1101, 7'h7F, 1'b1);                      // n22
        slot(4'b1101, 7'h7F, 2);
        slot(4'b1011, 7'h7F, 4);
        slot(4'b0111, 7'h7F, 4);
        slot(4'b1110, 7'h40, 4);                        // n33-36

        // Overflow with carry: value blinks with 32-cycle phases
        load = 1'b1; result = 4'b0011; zero = 1'b0; carry = 1'b1; overflow = 1'b1;
        cyc(4'b1101, 7'h7F, 1'b0);                      // n37
        load = 1'b0;
        cyc(4'b1101, 7'h7F, 1'b1);                      // n38
        slot(4'b1101, 7'h7F, 2);
        slot(4'b1011, 7'h46, 4);
        slot(4'b0111, 7'h23, 4);                        // n45-48
        frame_ovf(7'h30);                               // n49-64
        frame_ovf(7'h7F);                               // n65-80 blanked
        frame_ovf(7'h7F);                               // n81-96 blanked
        frame_ovf(7'h30);                               // n97-112
        frame_ovf(7'h30);                               // n113-128
        cyc(4'b1110, 7'h7F, 1'b0);                      // n129 blanked

        // Clearing overflow during the blank phase stops blinking at once
        load = 1'b1; overflow = 1'b0;
        cyc(4'b1110, 7'h7F, 1'b0);                      // n130
        load = 1'b0;
        cyc(4'b1110, 7'h30, 1'b1);                      // n131
        cyc(4'b1110, 7'h30, 1'b0);
        slot(4'b1101, 7'h7F, 4);
        slot(4'b1011, 7'h46, 4);
        slot(4'b0111, 7'h7F, 4);                        // n141-144
        slot(4'b1110, 7'h30, 4);
        slot(4'b1101, 7'h7F, 4);
        slot(4'b1011, 7'h46, 4);
        slot(4'b0111, 7'h7F, 4);                        // n157-160
        slot(4'b1110, 7'h30, 4);                        // would be blank if still blinking
        slot(4'b1101, 7'h7F, 4);
        slot(4'b1011, 7'h46, 2);                        // n169-170

        // Reset at idx=2, div_cnt=2 with a competing load
        rst_n = 1'b0; load = 1'b1; result = 4'b0111; overflow = 1'b1;
        tick();                                         // n171
        check("midrst an", {4'h0, an}, 8'h0F);
        check("midrst seg", {1'b0, seg}, 8'h7F);
        check("midrst ack", {7'h0, ack}, 8'h00);
        tick();
        check("midrst2 ack", {7'h0, ack}, 8'h00);
        rst_n = 1'b1; load = 1'b0;
        n = 0;
        cyc(4'b1110, 7'h40, 1'b0);                      // n1 after restart
        slot(4'b1110, 7'h40, 3);
        slot(4'b1101, 7'h7F, 4);
        slot(4'b1011, 7'h7F, 4);
        slot(4'b0111, 7'h7F, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
